// File: rtl/lfsr_rng_param.sv
// Parametrised Galois-LFSR random source with seeding, warm-up and a registered read port.
// Optional step counter output is built when RNG_STEP_COUNT_EN is defined.
module lfsr_rng_param #(
    parameter int unsigned          LFSR_W = 16,
    parameter int unsigned          OUT_W  = 2,
    parameter logic [LFSR_W-1:0]    TAPS   = LFSR_W'(16'hB400),
    parameter logic [LFSR_W-1:0]    SEED   = LFSR_W'(16'hACE1),
    parameter int unsigned          WARMUP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [OUT_W-1:0]  rd_data,
    output logic              busy
`ifdef RNG_STEP_COUNT_EN
    ,
    output logic [31:0]       step_cnt
`endif
);

    // Counter is at least one bit wide so WARMUP=0 still elaborates cleanly
    localparam int unsigned WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WARMUP);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } fsm_t;

    localparam fsm_t FSM_INIT = (WARMUP > 0) ? ST_WARMUP : ST_RUN;

    fsm_t              fsm_q;
    fsm_t              fsm_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              step_c;
    logic              rd_fire_c;
    logic              busy_c;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= FSM_INIT;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state: seeding restarts warm-up; the last warm-up step hands over to RUN
    always_comb begin
        fsm_d = fsm_q;
        if (seed_load) begin
            fsm_d = FSM_INIT;
        end else if ((fsm_q == ST_WARMUP) && en && (wcnt_q == WCNT_W'(1))) begin
            fsm_d = ST_RUN;
        end
    end

    // Datapath controls derived from the current FSM state and inputs
    always_comb begin
        step_c    = en && !seed_load;
        lfsr_d    = lfsr_q;
        wcnt_d    = wcnt_q;
        rd_fire_c = 1'b0;
        busy_c    = (fsm_d == ST_WARMUP);
        if (seed_load) begin
            lfsr_d = (seed_in == '0) ? SEED : seed_in;
            wcnt_d = WCNT_INIT;
        end else begin
            if (step_c) begin
                lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
            end
            if ((fsm_q == ST_WARMUP) && en) begin
                wcnt_d = wcnt_q - WCNT_W'(1);
            end
            rd_fire_c = rd_req && (fsm_q == ST_RUN);
        end
    end

    // Reads sample the state held before this edge's step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q   <= SEED;
            wcnt_q   <= WCNT_INIT;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            busy     <= (WARMUP > 0);
        end else begin
            lfsr_q   <= lfsr_d;
            wcnt_q   <= wcnt_d;
            rd_valid <= rd_fire_c;
            busy     <= busy_c;
            if (rd_fire_c) begin
                rd_data <= lfsr_q[OUT_W-1:0];
            end
        end
    end

`ifdef RNG_STEP_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (seed_load) begin
            step_cnt <= '0;
        end else if (step_c) begin
            step_cnt <= step_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rng_param.sv
// Bench for lfsr_rng_param: two instances (no warm-up, 4-step warm-up) against a behavioural model.
module tb_lfsr_rng_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        rd_req;
    logic        rd_valid0, rd_valid4;
    logic [15:0] rd_data0, rd_data4;
    logic        busy0, busy4;
`ifdef RNG_STEP_COUNT_EN
    logic [31:0] step_cnt0, step_cnt4;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_rng_param #(.LFSR_W(16), .OUT_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .WARMUP(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .rd_req(rd_req), .rd_valid(rd_valid0), .rd_data(rd_data0), .busy(busy0)
`ifdef RNG_STEP_COUNT_EN
        , .step_cnt(step_cnt0)
`endif
    );

    lfsr_rng_param #(.LFSR_W(16), .OUT_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .WARMUP(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .rd_req(rd_req), .rd_valid(rd_valid4), .rd_data(rd_data4), .busy(busy4)
`ifdef RNG_STEP_COUNT_EN
        , .step_cnt(step_cnt4)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: index 0 has no warm-up, index 1 has a 4-step warm-up
    logic [15:0] m_s[2];
    int          m_w[2];
    logic        m_v[2];
    logic [15:0] m_d[2];
    logic [31:0] m_c[2];
    logic [15:0] log0[$];
    logic [15:0] log4[$];
    bit          saw_zero;

    function automatic logic [15:0] nxt(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_s[k] <= 16'hACE1;
                m_w[k] <= (k == 0) ? 0 : 4;
                m_v[k] <= 1'b0;
                m_d[k] <= 16'h0000;
                m_c[k] <= 32'd0;
            end else begin
                if (m_s[k] == 16'h0000) saw_zero <= 1'b1;
                if (seed_load) begin
                    m_s[k] <= (seed_in == 16'h0000) ? 16'hACE1 : seed_in;
                    m_w[k] <= (k == 0) ? 0 : 4;
                    m_c[k] <= 32'd0;
                    m_v[k] <= 1'b0;
                end else begin
                    if (m_w[k] == 0 && rd_req) begin
                        m_v[k] <= 1'b1;
                        m_d[k] <= m_s[k];
                        if (k == 0) log0.push_back(m_s[k]);
                        else        log4.push_back(m_s[k]);
                    end else begin
                        m_v[k] <= 1'b0;
                    end
                    if (en) begin
                        m_s[k] <= nxt(m_s[k]);
                        m_c[k] <= m_c[k] + 32'd1;
                        if (m_w[k] > 0) m_w[k] <= m_w[k] - 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison, mid-cycle away from the active edge
    always @(negedge clk) begin
        chk("rd_valid0", 32'(rd_valid0), 32'(m_v[0]));
        chk("rd_data0",  32'(rd_data0),  32'(m_d[0]));
        chk("busy0",     32'(busy0),     32'(m_w[0] > 0));
        chk("rd_valid4", 32'(rd_valid4), 32'(m_v[1]));
        chk("rd_data4",  32'(rd_data4),  32'(m_d[1]));
        chk("busy4",     32'(busy4),     32'(m_w[1] > 0));
`ifdef RNG_STEP_COUNT_EN
        chk("step_cnt0", step_cnt0, m_c[0]);
        chk("step_cnt4", step_cnt4, m_c[1]);
`endif
    end

    task automatic drv(input logic e, input logic sl, input logic [15:0] sd, input logic r);
        @(posedge clk);
        #2;
        en = e; seed_load = sl; seed_in = sd; rd_req = r;
    endtask

    task automatic chk_log0(input string nm, input logic [15:0] exp[], input int n);
        chk({nm, "_count"}, 32'(log0.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < log0.size()) chk(nm, 32'(log0[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [15:0] exp_a[];
        reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_in = 16'h0; rd_req = 1'b0;
        saw_zero = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd1);
        chk("rst_valid0", 32'(rd_valid0), 32'd0);
        chk("rst_data0", 32'(rd_data0), 32'd0);

        // Free-running reads from reset seed; warm-up instance drops the first four
        log0.delete(); log4.delete();
        repeat (7) drv(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (2) drv(1'b0, 1'b0, 16'h0, 1'b0);
        exp_a = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
        chk_log0("seq_reset", exp_a, 7);
        chk("warm_reads", 32'(log4.size()), 32'd3);
        if (log4.size() > 0) chk("warm_first", 32'(log4[0]), 32'h1C4E);

        // Zero seed substitutes the reset seed; load-cycle read is dropped
        log0.delete();
        drv(1'b1, 1'b1, 16'h0000, 1'b1);
        repeat (3) drv(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (2) drv(1'b0, 1'b0, 16'h0, 1'b0);
        exp_a = '{16'hACE1, 16'hE270, 16'h7138};
        chk_log0("seed_zero", exp_a, 3);

        log0.delete();
        drv(1'b1, 1'b1, 16'h0001, 1'b1);
        repeat (3) drv(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (2) drv(1'b0, 1'b0, 16'h0, 1'b0);
        exp_a = '{16'h0001, 16'hB400, 16'h5A00};
        chk_log0("seed_one", exp_a, 3);

        // Held state repeats the same value
        log0.delete();
        repeat (3) drv(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) drv(1'b0, 1'b0, 16'h0, 1'b0);
        exp_a = '{16'h2D00, 16'h2D00, 16'h2D00};
        chk_log0("hold", exp_a, 3);

`ifdef RNG_STEP_COUNT_EN
        drv(1'b0, 1'b1, 16'h1234, 1'b0);
        repeat (10) drv(1'b1, 1'b0, 16'h0, 1'b0);
        drv(1'b0, 1'b0, 16'h0, 1'b0);
        chk("cnt_ten", step_cnt0, 32'd10);
        drv(1'b1, 1'b1, 16'h0005, 1'b0);
        drv(1'b0, 1'b0, 16'h0, 1'b0);
        chk("cnt_clear", step_cnt0, 32'd0);
`endif

        // Randomised traffic
        repeat (3000) begin
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset while a read response is on the port
        drv(1'b1, 1'b0, 16'h0, 1'b1);
        @(posedge clk);
        #1 chk("pre_rst_valid0", 32'(rd_valid0), 32'd1);
        #1 reset = 1'b1; en = 1'b0; seed_load = 1'b0; rd_req = 1'b0;
        #1;
        chk("mid_rst_valid0", 32'(rd_valid0), 32'd0);
        chk("mid_rst_valid4", 32'(rd_valid4), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Full period returns to the seed without passing through zero
        log0.delete();
        saw_zero = 1'b0;
        repeat (65535) drv(1'b1, 1'b0, 16'h0, 1'b0);
        drv(1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) drv(1'b0, 1'b0, 16'h0, 1'b0);
        exp_a = '{16'hACE1};
        chk_log0("period", exp_a, 1);
        chk("no_zero", 32'(saw_zero), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
